// File: rtl/pe_stream_scheduler_if.sv
// Bundles the control, GLB and PE stream signals of one PE stream scheduler.
// The scheduler connects through the master modport; the GLB/PE side uses slave.
interface pe_stream_scheduler_if #(
    parameter int DATA_BITS   = 32,
    parameter int ADDR_BITS   = 16,
    parameter int CONFIG_SIZE = 13
);
    logic                   start;
    logic [CONFIG_SIZE-1:0] cfg;
    logic [ADDR_BITS-1:0]   filter_base;
    logic [ADDR_BITS-1:0]   ifmap_base;
    logic [ADDR_BITS-1:0]   dw_ipsum_base;
    logic [ADDR_BITS-1:0]   pw_ipsum_base;
    logic [ADDR_BITS-1:0]   opsum_base;

    logic                   glb_ren;
    logic [ADDR_BITS-1:0]   glb_raddr;
    logic [DATA_BITS-1:0]   glb_rdata;
    logic                   glb_wen;
    logic [ADDR_BITS-1:0]   glb_waddr;
    logic [DATA_BITS-1:0]   glb_wdata;

    logic                   PE_en;
    logic [CONFIG_SIZE-1:0] i_config;
    logic [DATA_BITS-1:0]   ifmap;
    logic [DATA_BITS-1:0]   filter;
    logic [DATA_BITS-1:0]   depthwise_ipsum;
    logic [DATA_BITS-1:0]   pointwise_ipsum;
    logic                   ifmap_valid;
    logic                   filter_valid;
    logic                   depthwise_ipsum_valid;
    logic                   pointwise_ipsum_valid;
    logic                   ifmap_ready;
    logic                   filter_ready;
    logic                   depthwise_ipsum_ready;
    logic                   pointwise_ipsum_ready;
    logic [DATA_BITS-1:0]   opsum;
    logic                   opsum_valid;
    logic                   opsum_ready;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, cfg, filter_base, ifmap_base, dw_ipsum_base, pw_ipsum_base, opsum_base,
        input  glb_rdata,
        input  ifmap_ready, filter_ready, depthwise_ipsum_ready, pointwise_ipsum_ready,
        input  opsum, opsum_valid,
        output glb_ren, glb_raddr, glb_wen, glb_waddr, glb_wdata,
        output PE_en, i_config, ifmap, filter, depthwise_ipsum, pointwise_ipsum,
        output ifmap_valid, filter_valid, depthwise_ipsum_valid, pointwise_ipsum_valid,
        output opsum_ready, busy, done
    );

    modport slave (
        output start, cfg, filter_base, ifmap_base, dw_ipsum_base, pw_ipsum_base, opsum_base,
        output glb_rdata,
        output ifmap_ready, filter_ready, depthwise_ipsum_ready, pointwise_ipsum_ready,
        output opsum, opsum_valid,
        input  glb_ren, glb_raddr, glb_wen, glb_waddr, glb_wdata,
        input  PE_en, i_config, ifmap, filter, depthwise_ipsum, pointwise_ipsum,
        input  ifmap_valid, filter_valid, depthwise_ipsum_valid, pointwise_ipsum_valid,
        input  opsum_ready, busy, done
    );
endinterface

// File: rtl/pe_stream_scheduler.sv
// Walks one PE through a layer tile: config pulse, filter load, then per column
// ifmap / depthwise ipsum / pointwise ipsum reads from the GLB and opsum writes back.
module pe_stream_scheduler #(
    parameter int DATA_BITS   = 32,
    parameter int ADDR_BITS   = 16,
    parameter int CONFIG_SIZE = 13
) (
    input logic                clk,
    input logic                rst,
    pe_stream_scheduler_if.master bus
);
    localparam int NS = 4;  // read streams: 0 filter, 1 ifmap, 2 dw ipsum, 3 pw ipsum

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_FILTER, S_IFMAP, S_DW, S_PW, S_OPSUM, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CONFIG_SIZE-1:0] cfg_q;
    logic [ADDR_BITS-1:0]   rptr_q [NS];
    logic [ADDR_BITS-1:0]   base_w [NS];
    logic [ADDR_BITS-1:0]   wptr_q;
    logic [4:0]             col_q, col_d;
    logic [5:0]             issue_q, issue_d;
    logic [5:0]             remain_q, remain_d;
    logic                   inflight_q;
    logic                   hold_valid_q;
    logic [DATA_BITS-1:0]   hold_q;

    logic [5:0] p_w, q_w, rs_w, filt_cnt, dw_cnt, ifm0_cnt, cnt_val;
    logic [1:0] sid;
    logic       in_stream, ready_sel, xfer, ren, wr, last, start_acc, cnt_load;

    assign base_w[0] = bus.filter_base;
    assign base_w[1] = bus.ifmap_base;
    assign base_w[2] = bus.dw_ipsum_base;
    assign base_w[3] = bus.pw_ipsum_base;

    assign p_w      = {4'd0, cfg_q[8:7]} + 6'd1;
    assign q_w      = {4'd0, cfg_q[1:0]} + 6'd1;
    assign rs_w     = {4'd0, cfg_q[11:10]} + 6'd1;
    assign filt_cnt = p_w * rs_w;
    assign dw_cnt   = cfg_q[12] ? q_w : p_w;
    assign ifm0_cnt = rs_w;

    always_comb begin
        sid       = 2'd0;
        in_stream = 1'b0;
        ready_sel = 1'b0;
        case (state_q)
            S_FILTER: begin sid = 2'd0; in_stream = 1'b1; ready_sel = bus.filter_ready;          end
            S_IFMAP:  begin sid = 2'd1; in_stream = 1'b1; ready_sel = bus.ifmap_ready;           end
            S_DW:     begin sid = 2'd2; in_stream = 1'b1; ready_sel = bus.depthwise_ipsum_ready; end
            S_PW:     begin sid = 2'd3; in_stream = 1'b1; ready_sel = bus.pointwise_ipsum_ready; end
            default:  ;
        endcase
    end

    assign xfer = in_stream && hold_valid_q && ready_sel;
    // A new read may only be issued once the holding register is free or emptying now.
    assign ren  = in_stream && (issue_q != 6'd0) && !inflight_q && (!hold_valid_q || xfer);
    assign wr   = (state_q == S_OPSUM) && bus.opsum_valid;
    assign last = (remain_q == 6'd1);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        start_acc = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = 6'd0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d   = S_CFG;
                start_acc = 1'b1;
                col_d     = 5'd0;
            end
            S_CFG: begin
                state_d  = S_FILTER;
                cnt_load = 1'b1;
                cnt_val  = filt_cnt;
            end
            S_FILTER: if (xfer && last) begin
                state_d  = S_IFMAP;
                cnt_load = 1'b1;
                cnt_val  = ifm0_cnt;
            end
            S_IFMAP: if (xfer && last) begin
                state_d  = S_DW;
                cnt_load = 1'b1;
                cnt_val  = dw_cnt;
            end
            S_DW: if (xfer && last) begin
                state_d  = cfg_q[12] ? S_PW : S_OPSUM;
                cnt_load = 1'b1;
                cnt_val  = cfg_q[12] ? 6'd4 : p_w;
            end
            S_PW: if (xfer && last) begin
                state_d  = S_OPSUM;
                cnt_load = 1'b1;
                cnt_val  = p_w;
            end
            S_OPSUM: if (wr && last) begin
                cnt_load = 1'b1;
                if (col_q == cfg_q[6:2]) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IFMAP;
                    col_d   = col_q + 5'd1;
                    cnt_val = 6'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        issue_d  = ren ? issue_q - 6'd1 : issue_q;
        remain_d = (xfer || wr) ? remain_q - 6'd1 : remain_q;
        if (cnt_load) begin
            remain_d = cnt_val;
            issue_d  = (state_d == S_OPSUM || state_d == S_DONE) ? 6'd0 : cnt_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cfg_q        <= '0;
            wptr_q       <= '0;
            col_q        <= '0;
            issue_q      <= '0;
            remain_q     <= '0;
            inflight_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            for (int i = 0; i < NS; i++) rptr_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            issue_q    <= issue_d;
            remain_q   <= remain_d;
            inflight_q <= ren;
            if (start_acc) begin
                cfg_q  <= bus.cfg;
                wptr_q <= bus.opsum_base;
            end else if (wr) begin
                wptr_q <= wptr_q + 1'b1;
            end
            for (int i = 0; i < NS; i++) begin
                if (start_acc)
                    rptr_q[i] <= base_w[i];
                else if (ren && sid == 2'(i))
                    rptr_q[i] <= rptr_q[i] + 1'b1;
            end
            if (inflight_q) begin
                hold_q       <= bus.glb_rdata;
                hold_valid_q <= 1'b1;
            end else if (xfer) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

    assign bus.glb_ren               = ren;
    assign bus.glb_raddr             = ren ? rptr_q[sid] : '0;
    assign bus.glb_wen               = wr;
    assign bus.glb_waddr             = wr ? wptr_q : '0;
    assign bus.glb_wdata             = wr ? bus.opsum : '0;
    assign bus.PE_en                 = (state_q == S_CFG);
    assign bus.i_config              = cfg_q;
    assign bus.filter                = hold_q;
    assign bus.ifmap                 = hold_q;
    assign bus.depthwise_ipsum       = hold_q;
    assign bus.pointwise_ipsum       = hold_q;
    assign bus.filter_valid          = (state_q == S_FILTER) && hold_valid_q;
    assign bus.ifmap_valid           = (state_q == S_IFMAP) && hold_valid_q;
    assign bus.depthwise_ipsum_valid = (state_q == S_DW) && hold_valid_q;
    assign bus.pointwise_ipsum_valid = (state_q == S_PW) && hold_valid_q;
    assign bus.opsum_ready           = (state_q == S_OPSUM);
    assign bus.busy                  = (state_q != S_IDLE);
    assign bus.done                  = (state_q == S_DONE);
endmodule

// File: tb/tb_pe_stream_scheduler.sv
// Bench for pe_stream_scheduler: a GLB memory model, a PE-side driver and a scoreboard
// of expected read addresses, streamed words and opsum writes built from the tile config.
module tb_pe_stream_scheduler;
    localparam int DB = 32;
    localparam int AB = 16;
    localparam int CS = 13;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_stream_scheduler_if #(.DATA_BITS(DB), .ADDR_BITS(AB), .CONFIG_SIZE(CS)) bus ();
    pe_stream_scheduler #(.DATA_BITS(DB), .ADDR_BITS(AB), .CONFIG_SIZE(CS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem_f(input logic [15:0] a);
        return {16'hDA7A, a ^ 16'h5A5A};
    endfunction

    always @(posedge clk) if (bus.glb_ren) bus.glb_rdata <= mem_f(bus.glb_raddr);

    typedef struct {
        logic [12:0] cfg;
        logic [15:0] fb, ib, db, pb, ob;
        int          rmode;   // 0 ready=1, 1 filter_ready 1,0,0,1, 2 random readies
        int          gap;     // opsum_valid every gap cycles
        bit          restart; // second start pulse at cycle 5
        int          n_rd;
        int          n_wr;
    } vec_t;

    typedef struct packed { logic [1:0] sid; logic [15:0] addr; } rd_t;
    typedef struct packed { logic [15:0] addr; logic [31:0] data; } wr_t;

    rd_t exp_rd[$];
    rd_t pend[$];
    wr_t exp_wr[$];
    vec_t vecs[5];

    int errors = 0;
    int checks = 0;
    int rd_cnt, wr_cnt, done_cnt, pe_cnt, wr_sent, prev_sid;
    bit prev_stall;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_model(input vec_t v);
        int p, q, rs, f, w;
        logic [15:0] a_f, a_i, a_d, a_p, a_o;
        p = int'(v.cfg[8:7]) + 1; q = int'(v.cfg[1:0]) + 1;
        rs = int'(v.cfg[11:10]) + 1; f = int'(v.cfg[6:2]);
        a_f = v.fb; a_i = v.ib; a_d = v.db; a_p = v.pb; a_o = v.ob; w = 0;
        exp_rd.delete(); pend.delete(); exp_wr.delete();
        for (int i = 0; i < p * rs; i++) begin exp_rd.push_back('{2'd0, a_f}); a_f++; end
        for (int c = 0; c <= f; c++) begin
            for (int i = 0; i < ((c == 0) ? rs : 1); i++) begin exp_rd.push_back('{2'd1, a_i}); a_i++; end
            for (int i = 0; i < (v.cfg[12] ? q : p); i++) begin exp_rd.push_back('{2'd2, a_d}); a_d++; end
            for (int i = 0; i < (v.cfg[12] ? 4 : 0); i++) begin exp_rd.push_back('{2'd3, a_p}); a_p++; end
            for (int i = 0; i < p; i++) begin
                exp_wr.push_back('{a_o, 32'hC0DE0000 + 32'(w)});
                a_o++; w++;
            end
        end
    endtask

    task automatic tick(input vec_t v, input int k);
        logic [3:0] vld, rdy, xf;
        logic [31:0] dat [4];
        rd_t e;
        wr_t ew;
        bit hs;
        @(negedge clk);
        bus.start = v.restart && (k == 5);
        bus.cfg   = (v.restart && k == 5) ? ~v.cfg : v.cfg;
        case (v.rmode)
            0: begin
                bus.filter_ready = 1'b1; bus.ifmap_ready = 1'b1;
                bus.depthwise_ipsum_ready = 1'b1; bus.pointwise_ipsum_ready = 1'b1;
            end
            1: begin
                bus.filter_ready = (k % 4 == 0) || (k % 4 == 3); bus.ifmap_ready = 1'b1;
                bus.depthwise_ipsum_ready = 1'b1; bus.pointwise_ipsum_ready = 1'b1;
            end
            default: begin
                bus.filter_ready = 1'($urandom_range(0, 1));
                bus.ifmap_ready = 1'($urandom_range(0, 1));
                bus.depthwise_ipsum_ready = 1'($urandom_range(0, 1));
                bus.pointwise_ipsum_ready = 1'($urandom_range(0, 1));
            end
        endcase
        bus.opsum_valid = (k % v.gap) == 0;
        bus.opsum       = 32'hC0DE0000 + 32'(wr_sent);
        #1;
        vld = {bus.pointwise_ipsum_valid, bus.depthwise_ipsum_valid, bus.ifmap_valid, bus.filter_valid};
        rdy = {bus.pointwise_ipsum_ready, bus.depthwise_ipsum_ready, bus.ifmap_ready, bus.filter_ready};
        dat[0] = bus.filter; dat[1] = bus.ifmap; dat[2] = bus.depthwise_ipsum; dat[3] = bus.pointwise_ipsum;
        xf = vld & rdy;
        if (vld != 4'd0) check("one_valid", 32'($countones(vld)), 32'd1);
        if (prev_stall) begin
            check("stall_valid_held", 32'(vld[prev_sid]), 32'd1);
            check("stall_data_held", dat[prev_sid], prev_data);
        end
        if (bus.glb_ren) begin
            rd_cnt++;
            check("ren_while_holding", 32'((vld != 4'd0) && (xf == 4'd0)), 32'd0);
            if (exp_rd.size() == 0) check("extra_read", 32'(bus.glb_raddr), 32'hFFFFFFFF);
            else begin
                e = exp_rd.pop_front();
                check("raddr", 32'(bus.glb_raddr), 32'(e.addr));
                pend.push_back(e);
            end
        end
        prev_stall = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (xf[s]) begin
                if (pend.size() == 0) check("xfer_without_read", 32'(s), 32'hFFFFFFFF);
                else begin
                    e = pend.pop_front();
                    check("xfer_stream", 32'(s), 32'(e.sid));
                    check("xfer_data", dat[s], mem_f(e.addr));
                end
            end else if (vld[s]) begin
                prev_stall = 1'b1; prev_sid = s; prev_data = dat[s];
            end
        end
        hs = bus.opsum_valid && bus.opsum_ready;
        if (hs || bus.glb_wen) begin
            check("wen_on_handshake", 32'(bus.glb_wen), 32'(hs));
            if (hs) begin
                wr_cnt++; wr_sent++;
                if (exp_wr.size() == 0) check("extra_write", 32'(bus.glb_waddr), 32'hFFFFFFFF);
                else begin
                    ew = exp_wr.pop_front();
                    check("waddr", 32'(bus.glb_waddr), 32'(ew.addr));
                    check("wdata", bus.glb_wdata, ew.data);
                end
            end
        end
        if (bus.PE_en) begin
            pe_cnt++;
            check("i_config_at_pe_en", 32'(bus.i_config), 32'(v.cfg));
        end
        if (bus.done) begin
            done_cnt++;
            check("busy_at_done", 32'(bus.busy), 32'd1);
            check("i_config_at_done", 32'(bus.i_config), 32'(v.cfg));
        end
    endtask

    task automatic launch(input vec_t v);
        build_model(v);
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; pe_cnt = 0; wr_sent = 0; prev_stall = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.cfg = v.cfg;
        bus.filter_base = v.fb; bus.ifmap_base = v.ib; bus.dw_ipsum_base = v.db;
        bus.pw_ipsum_base = v.pb; bus.opsum_base = v.ob;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic run(input vec_t v, input int idx);
        int k;
        launch(v);
        k = 0;
        while (k < 3000 && done_cnt == 0) begin tick(v, k); k++; end
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
        else begin
            tick(v, k);
            check("busy_after_done", 32'(bus.busy), 32'd0);
            for (int i = 1; i < 8; i++) tick(v, k + i);
        end
        check("done_count", 32'(done_cnt), 32'd1);
        check("pe_en_count", 32'(pe_cnt), 32'd1);
        check("read_count", 32'(rd_cnt), 32'(v.n_rd));
        check("write_count", 32'(wr_cnt), 32'(v.n_wr));
        check("reads_left", 32'(exp_rd.size() + pend.size()), 32'd0);
        check("writes_left", 32'(exp_wr.size()), 32'd0);
        $display("tile %0d cfg=%h reads=%0d writes=%0d dones=%0d cycles=%0d", idx, v.cfg, rd_cnt, wr_cnt, done_cnt, k);
    endtask

    initial begin
        int k;
        vecs[0] = '{13'h0886, 16'd0,   16'd100, 16'd200,    16'd300, 16'd400,    0, 1, 1'b1, 14, 4};
        vecs[1] = '{13'h1982, 16'd0,   16'd100, 16'd200,    16'd300, 16'd400,    0, 1, 1'b0, 22, 4};
        vecs[2] = '{13'h0886, 16'd0,   16'd100, 16'd200,    16'd300, 16'd400,    1, 1, 1'b0, 14, 4};
        vecs[3] = '{13'h0508, 16'd10,  16'd120, 16'd220,    16'd320, 16'd420,    0, 3, 1'b0, 19, 9};
        vecs[4] = '{13'h100F, 16'd500, 16'd600, 16'hFFFE,   16'd700, 16'hFFFD,   2, 2, 1'b0, 37, 4};

        bus.start = 1'b0; bus.cfg = '0; bus.opsum = '0; bus.opsum_valid = 1'b0;
        bus.filter_base = '0; bus.ifmap_base = '0; bus.dw_ipsum_base = '0;
        bus.pw_ipsum_base = '0; bus.opsum_base = '0;
        bus.filter_ready = 1'b0; bus.ifmap_ready = 1'b0;
        bus.depthwise_ipsum_ready = 1'b0; bus.pointwise_ipsum_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_glb_ren", 32'(bus.glb_ren), 32'd0);
        check("reset_pe_en", 32'(bus.PE_en), 32'd0);
        check("reset_i_config", 32'(bus.i_config), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) run(vecs[i], i);

        // Reset while the ifmap stream is presenting data, then replay the same tile.
        launch(vecs[0]);
        k = 0;
        while (k < 200 && !bus.ifmap_valid) begin tick(vecs[0], k); k++; end
        check("reached_ifmap", 32'(bus.ifmap_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_glb_ren", 32'(bus.glb_ren), 32'd0);
        check("rst_ifmap_valid", 32'(bus.ifmap_valid), 32'd0);
        check("rst_ifmap_data", bus.ifmap, 32'd0);
        check("rst_i_config", 32'(bus.i_config), 32'd0);
        check("rst_opsum_ready", 32'(bus.opsum_ready), 32'd0);
        #2 rst = 1'b1;
        prev_stall = 1'b0; done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(vecs[1], 100 + i);
            check("post_rst_idle", 32'(bus.busy), 32'd0);
        end
        check("post_rst_no_done", 32'(done_cnt), 32'd0);
        run(vecs[0], 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pe_stream_scheduler.md
Name: pe_stream_scheduler

Overview:
- Sequences one SUPER-style PE through a full layer tile: configures it, then feeds filter, ifmap, depthwise-ipsum and pointwise-ipsum words from a single shared GLB read port, and writes returned opsums to the GLB write port.
- Sits between the global buffer and one PE.
- Owns all word counting and address generation, so the PE only sees valid/ready streams in the order it consumes them.

Parameters:
- DATA_BITS, 32, GLB and stream word width
- ADDR_BITS, 16, GLB word-address width
- CONFIG_SIZE, 13, PE config width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; launches a tile when idle
- cfg  in  CONFIG_SIZE  [12] depthwise, [11:10] rs-1, [9] mode, [8:7] p-1, [6:2] F, [1:0] q-1
- filter_base, ifmap_base, dw_ipsum_base, pw_ipsum_base, opsum_base  in  ADDR_BITS each  GLB start addresses
- glb_ren  out  1  GLB read enable
- glb_raddr  out  ADDR_BITS  GLB read address
- glb_rdata  in  DATA_BITS  GLB read data; valid exactly 1 cycle after glb_ren
- glb_wen  out  1  GLB write enable
- glb_waddr  out  ADDR_BITS  GLB write address
- glb_wdata  out  DATA_BITS  GLB write data
- PE_en  out  1  PE enable
- i_config  out  CONFIG_SIZE  PE config; holds cfg latched at start
- ifmap, filter, depthwise_ipsum, pointwise_ipsum  out  DATA_BITS each  stream data; all driven from one shared holding register
- ifmap_valid, filter_valid, depthwise_ipsum_valid, pointwise_ipsum_valid  out  1 each  stream valids
- ifmap_ready, filter_ready, depthwise_ipsum_ready, pointwise_ipsum_ready  in  1 each  from PE
- opsum  in  DATA_BITS  PE output
- opsum_valid  in  1  from PE
- opsum_ready  out  1  to PE
- busy  out  1  high from the start-accept cycle until DONE exits
- done  out  1  one-cycle pulse when the tile completes

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; all counters, pointers and the holding register clear.
  - All outputs go to 0; i_config goes to 0.
  - Reset mid-tile aborts the tile. No done pulse is produced.
- Derived values, latched at start: p=cfg[8:7]+1, q=cfg[1:0]+1, rs=cfg[11:10]+1, COLS=F+1.
- Per-tile word counts:
  - Filter: p*rs words, loaded once per tile.
  - Ifmap: rs words for column 0, 1 word for each later column.
  - Depthwise ipsum: depthwise ? q : p words per column.
  - Pointwise ipsum: depthwise ? 4 : 0 words per column.
  - Opsum: p words per column.
- State machine:
  - IDLE: on start, latch cfg and the base addresses, then go to CFG. A start pulse in any other state is ignored.
  - CFG: PE_en=1 for exactly one cycle, with i_config valid in the same cycle. Next state is FILTER.
  - FILTER, then per column: IFMAP -> DW_IPSUM -> PW_IPSUM (skipped when depthwise=0) -> OPSUM.
  - After OPSUM, when the column counter equals COLS-1, go to DONE; otherwise increment the column counter and go to IFMAP.
  - DONE: done=1 for one cycle, then IDLE.
- Read path:
  - One holding register plus a hold_valid flag, shared by all streams. Only the current state's stream valid is driven: it equals hold_valid.
  - A transfer occurs when that valid and the matching ready are both high.
  - glb_ren is asserted when words_remaining_issue>0 and (no read in flight) and (hold_valid=0 or a transfer occurs this cycle).
  - Consequence: with ready held high, throughput is one word per 2 cycles. First data appears 2 cycles after entering a stream state.
- Pointers:
  - Each stream has its own read pointer, initialised to its base at start and incremented by 1 per issued read.
  - Pointers are never rewound; ipsum pointers advance across columns.
  - Each stream state exits on the cycle after its final transfer. No read may ever be issued past a stream's count.
- Write path:
  - In OPSUM: opsum_ready=1.
  - On opsum_valid&&opsum_ready: glb_wen=1, glb_wdata=opsum, glb_waddr=opsum pointer. The opsum pointer starts at opsum_base and increments by 1 per write.
  - Outside OPSUM: opsum_ready=0 and glb_wen=0.
- Widths:
  - Word-count products use 6-bit unsigned arithmetic (max p*rs=16).
  - Address adds wrap modulo 2^ADDR_BITS; there is no overflow flag.

Test Plan:
- Normal conv, cfg p=2,q=3,rs=3,F=1, bases 0/100/200/300/400, ready/valid always 1:
  - Filter addrs 0..5, ifmap 100..102, then 103.
  - dw_ipsum 200,201 then 202,203; no pointwise reads.
  - 4 writes at 400..403; done pulses once, busy drops the following cycle.
- Depthwise, p=4,q=3,rs=3,F=0:
  - Reads 12 filter, 3 ifmap, 3 dw_ipsum (200..202), 4 pw_ipsum (300..303).
  - 4 opsum writes; total PE_en pulses = 1.
- Backpressure: filter_ready toggles 1,0,0,1:
  - Holding register stays stable while ready=0; no duplicated or dropped word; glb_ren never issues with hold_valid=1 and no transfer.
- Opsum gaps: opsum_valid asserted every 3rd cycle:
  - glb_wen only on those cycles; addresses consecutive.
- Start while busy: second start at cycle 5:
  - Ignored; cfg change has no effect on i_config; exactly one done.
- Reset mid-ifmap:
  - rst=0 for 1 cycle; all outputs 0 asynchronously; no done.
  - A subsequent start replays from filter_base.
